mult_seq: RTL and testbench
===========================

// Module: mult_seq
// PURPOSE
//  Parametrised iterative shift-add multiplier; next generation of the 4-bit combinational multiplier and its staging register.
//  Accepts two WIDTH-bit operands on a start/ready handshake and computes one product bit-step per clock.
//  Supports unsigned and two's-complement signed operands, then holds the 2*WIDTH-bit product until the next accept.
//  Sits in the arithmetic datapath as a small-area replacement for the combinational multiplier.
// PARAMETERS
//  WIDTH   8   operand width in bits, even, >= 2; product is 2*WIDTH bits
//  CNT_W   $clog2(WIDTH+1)   iteration counter width (derived localparam, not overridable)
// PORTS
//  clk          input   1          clock, rising edge active
//  rst          input   1          asynchronous active-low reset
//  start        input   1          request; accepted on a rising edge when ready=1
//  signed_mode  input   1          1 = operands are two's complement; sampled with a/b on accept
//  a            input   WIDTH      multiplicand, sampled on accept
//  b            input   WIDTH      multiplier, sampled on accept
//  ready        output  1          1 when a new start is accepted (state IDLE or DONE)
//  busy         output  1          1 while iterating (state RUN)
//  done         output  1          one-cycle pulse: mr holds a new valid product
//  mr           output  2*WIDTH    product register; held stable outside RUN
// BEHAVIOUR
//  Clock: single clock clk. Reset: asynchronous, active-low (rst=0 clears immediately, independent of clk).
//  Reset values: state=IDLE, mr=0, done=0, busy=0, ready=1, counter=0, internal operand regs=0.
//  Reset mid-operation aborts the operation. No partial product reaches mr; mr=0.
//  States:
//   IDLE -> RUN on start=1.
//   RUN -> DONE after WIDTH iterations.
//   DONE -> RUN if start=1, else DONE -> IDLE.
//  Accept edge (start=1 and ready=1):
//   - latch |a|, |b| into magnitude regs (magnitude only when signed_mode=1 and the MSB is set)
//   - latch neg = signed_mode & (a[W-1] ^ b[W-1])
//   - clear accumulator; counter=0; go to RUN
//  RUN, each edge:
//   - if multiplier LSB=1, add multiplicand to upper accumulator half, carry included
//   - shift {carry, acc} right by 1; counter+1
//   - after the WIDTH-th RUN edge: mr <= neg ? -acc : acc (2*WIDTH-bit two's complement); go to DONE
//  Latency: done=1 during the cycle after the (WIDTH+1)-th rising edge counted from the accept edge inclusive, i.e. WIDTH RUN edges follow accept.
//  done is high exactly one cycle per product; ready = (state!=RUN); busy = (state==RUN).
//  start while busy=1 is ignored; there is no queueing and operands are not re-sampled.
//  start in DONE is accepted: done still pulses that cycle, mr keeps the old product until the new result is written.
//  mr updates only on the final RUN edge or on reset; it never shows intermediate values.
//  Width rules:
//   - operand magnitudes use WIDTH bits, so -2^(W-1) gives magnitude 2^(W-1) without overflow
//   - product is exact in 2*WIDTH bits for all inputs
//  Unsigned mode: a, b in [0, 2^W-1]; neg forced to 0.
// STRUCTURE
//  Shared package mult_pkg: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; default MULT_WIDTH=8.
//  One sub-module: add_sub_n #(WIDTH), a ripple adder with cin/cout that does the per-step add.
//  The final negation is a second instance with invert-and-add-1 (cin=1).
//  FSM, counter and shift register stay in mult_seq.
// TESTING (WIDTH=8 unless noted)
//  1. rst pulsed low mid-RUN (a=200, b=3) -> mr=0, done=0, ready=1 asynchronously; next start a=2, b=3 -> mr=6.
//  2. Unsigned a=255, b=255, signed_mode=0 -> done after 9 edges from accept, mr=16'hFE01, mr stable until next accept.
//  3. Signed a=8'h80, b=8'h80 -> mr=16'h4000; a=8'h80, b=8'h01 -> mr=16'hFF80; a=8'hFF, b=8'h02 -> mr=16'hFFFE.
//  4. start held high through RUN with changing a/b -> operands ignored, one product per accept, done single-cycle.
//  5. start asserted in DONE cycle, back-to-back a=7, b=6 then a=0, b=9 -> mr=42 then 0, each with its own done pulse.
//  6. WIDTH=4 exhaustive plus WIDTH=16 random (1000 vectors, both modes) -> mr equals the reference a*b, compared with ===.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM state encodings and default width.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MULT_WIDTH = 8;

endpackage

// File: rtl/add_sub_n.sv
// Ripple-carry adder with optional B inversion; sub=1 with cin=1 gives a - b.
module add_sub_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic bx;
      assign bx          = b[gi] ^ sub;
      assign sum[gi]     = a[gi] ^ bx ^ carry[gi];
      assign carry[gi+1] = (a[gi] & bx) | (carry[gi] & (a[gi] ^ bx));
    end
  endgenerate

  assign cout = carry[WIDTH];

endmodule

// File: rtl/mult_seq.sv
// Iterative shift-add multiplier, one product bit per clock; signed operands are
// multiplied as magnitudes and the result is negated on the final step.
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] mr
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic               neg_reg;
  logic [2*WIDTH-1:0] mr_reg;
  logic               done_reg;

  logic               accept;
  logic               last;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] neg_sum;
  logic               neg_zero;
  logic [2*WIDTH-1:0] mr_next;

  assign accept = start && (state_reg != ST_RUN);
  assign last   = (state_reg == ST_RUN) && (cnt_reg == CNT_W'(WIDTH - 1));

  // Magnitudes fit in WIDTH bits unsigned, including the most negative value.
  assign a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

  add_sub_n #(.WIDTH(WIDTH)) u_step_add (
    .a    (acc_reg[2*WIDTH-1:WIDTH]),
    .b    (mcand_reg & {WIDTH{acc_reg[0]}}),
    .sub  (1'b0),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // The consumed multiplier bit falls off the bottom as the carry enters the top.
  assign acc_step = {add_cout, add_sum, acc_reg[WIDTH-1:1]};

  add_sub_n #(.WIDTH(2 * WIDTH)) u_negate (
    .a    ('0),
    .b    (acc_step),
    .sub  (1'b1),
    .cin  (1'b1),
    .sum  (neg_sum),
    .cout (neg_zero)
  );

  assign mr_next = (neg_reg && !neg_zero) ? neg_sum : acc_step;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last)  state_next = ST_DONE;
      ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      mcand_reg <= '0;
      acc_reg   <= '0;
      neg_reg   <= 1'b0;
      mr_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= last;
      if (accept) begin
        mcand_reg <= a_mag;
        acc_reg   <= {{WIDTH{1'b0}}, b_mag};
        neg_reg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        cnt_reg   <= '0;
      end else if (state_reg == ST_RUN) begin
        acc_reg <= acc_step;
        cnt_reg <= cnt_reg + CNT_W'(1);
        if (last) mr_reg <= mr_next;
      end
    end
  end

  assign ready = (state_reg != ST_RUN);
  assign busy  = (state_reg == ST_RUN);
  assign done  = done_reg;
  assign mr    = mr_reg;

endmodule

// File: tb/tb_mult_seq.sv
// Directed and reference-checked bench for mult_seq at WIDTH 8, 4 and 16.
module tb_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start8, sm8, ready8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] mr8;

  logic        start4, sm4, ready4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  mr4;

  logic        start16, sm16, ready16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] mr16;

  int vecs = 0;
  int errs = 0;

  mult_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .mr(mr8)
  );

  mult_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4), .a(a4), .b(b4),
    .ready(ready4), .busy(busy4), .done(done4), .mr(mr4)
  );

  mult_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16), .a(a16), .b(b16),
    .ready(ready16), .busy(busy16), .done(done16), .mr(mr16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic go8(input logic sm, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!done8 && n < 40);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0]  e4a, e4b, e4p;
    logic [31:0] e16a, e16b, e16p;

    rst = 1'b0;
    start8 = 0; sm8 = 0; a8 = 0; b8 = 0;
    start4 = 0; sm4 = 0; a4 = 0; b4 = 0;
    start16 = 0; sm16 = 0; a16 = 0; b16 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mr",    32'(mr8), 32'h0);
    chk("rst_done",  32'(done8), 32'h0);
    chk("rst_ready", 32'(ready8), 32'h1);
    chk("rst_busy",  32'(busy8), 32'h0);
    @(negedge clk);
    #4 rst = 1'b1;

    // Unsigned max operands, latency and hold
    go8(1'b0, 8'd255, 8'd255);
    wait_done8(n);
    chk("u255_lat", 32'(n), 32'd8);
    chk("u255_mr",  32'(mr8), 32'hFE01);
    repeat (5) @(posedge clk);
    #1;
    chk("u255_hold", 32'(mr8), 32'hFE01);
    chk("u255_pulse", 32'(done8), 32'h0);

    // Signed corner cases
    go8(1'b1, 8'h80, 8'h80); wait_done8(n);
    chk("s80x80", 32'(mr8), 32'h4000);
    go8(1'b1, 8'h80, 8'h01); wait_done8(n);
    chk("s80x01", 32'(mr8), 32'hFF80);
    go8(1'b1, 8'hFF, 8'h02); wait_done8(n);
    chk("sFFx02", 32'(mr8), 32'hFFFE);

    // Asynchronous reset mid-operation
    go8(1'b0, 8'd200, 8'd3);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy8), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_mr",    32'(mr8), 32'h0);
    chk("abort_done",  32'(done8), 32'h0);
    chk("abort_ready", 32'(ready8), 32'h1);
    #3 rst = 1'b1;
    go8(1'b0, 8'd2, 8'd3); wait_done8(n);
    chk("after_abort", 32'(mr8), 32'd6);

    // Back-to-back accept in the DONE cycle
    go8(1'b0, 8'd7, 8'd6); wait_done8(n);
    chk("b2b_first", 32'(mr8), 32'd42);
    go8(1'b0, 8'd0, 8'd9);
    chk("b2b_busy", 32'(busy8), 32'h1);
    chk("b2b_keep", 32'(mr8), 32'd42);
    wait_done8(n);
    chk("b2b_lat",    32'(n), 32'd8);
    chk("b2b_second", 32'(mr8), 32'd0);

    // start held through RUN with scrambled operands
    @(negedge clk);
    sm8 = 1'b0; a8 = 8'd10; b8 = 8'd11; start8 = 1'b1;
    @(posedge clk);
    #1 n = 0;
    do begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk);
      #1 n++;
    end while (!done8 && n < 40);
    chk("held_lat", 32'(n), 32'd8);
    chk("held_mr",  32'(mr8), 32'd110);
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk);
    #1;
    chk("held_pulse", 32'(done8), 32'h0);
    chk("held_idle",  32'(busy8), 32'h0);
    chk("held_keep",  32'(mr8), 32'd110);

    // WIDTH=4 exhaustive, both modes
    for (int sm = 0; sm < 2; sm++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          @(negedge clk);
          sm4 = sm[0]; a4 = 4'(ia); b4 = 4'(ib); start4 = 1'b1;
          @(posedge clk);
          #1 start4 = 1'b0;
          n = 0;
          do begin
            @(posedge clk);
            #1 n++;
          end while (!done4 && n < 30);
          e4a = sm[0] ? {{4{a4[3]}}, a4} : {4'b0, a4};
          e4b = sm[0] ? {{4{b4[3]}}, b4} : {4'b0, b4};
          e4p = e4a * e4b;
          chk($sformatf("w4 s%0d %0h*%0h", sm, a4, b4), 32'(mr4), 32'(e4p));
        end
      end
    end

    // WIDTH=16 random, both modes
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      sm16 = k[0]; a16 = 16'($urandom); b16 = 16'($urandom); start16 = 1'b1;
      @(posedge clk);
      #1 start16 = 1'b0;
      n = 0;
      do begin
        @(posedge clk);
        #1 n++;
      end while (!done16 && n < 40);
      e16a = sm16 ? {{16{a16[15]}}, a16} : {16'b0, a16};
      e16b = sm16 ? {{16{b16[15]}}, b16} : {16'b0, b16};
      e16p = e16a * e16b;
      chk($sformatf("w16 s%0d %0h*%0h", sm16, a16, b16), mr16, e16p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
